// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-execute bus: forwarding selects, ID-side fields, and the registered EX-side fields.
// The stage owns the slave side. The fetch/decode logic, or a bench, owns the master side.
interface id_ex_operand_stage_if #(
  parameter int DW  = 32,
  parameter int RW  = 4,
  parameter int OPW = 6,
  parameter int CW  = 16
);
  logic           stall;
  logic           flush;
  logic [1:0]     fwa;
  logic [1:0]     fwb;
  logic [DW-1:0]  rf_a;
  logic [DW-1:0]  rf_b;
  logic [DW-1:0]  ex_fwd;
  logic [DW-1:0]  mem_fwd;
  logic [DW-1:0]  wb_fwd;
  logic [DW-1:0]  id_imm;
  logic           id_valid;
  logic [OPW-1:0] id_op_code;
  logic [RW-1:0]  id_rd;
  logic           id_rw;
  logic           id_mem_rd;
  logic           id_mem_wr;
  logic [DW-1:0]  ex_a;
  logic [DW-1:0]  ex_b;
  logic [DW-1:0]  ex_imm;
  logic [OPW-1:0] ex_op_code;
  logic [RW-1:0]  ex_rd;
  logic           ex_rw;
  logic           ex_mem_rd;
  logic           ex_mem_wr;
  logic           ex_valid;
  logic           pc_write;
  logic           ifid_write;
  logic [CW-1:0]  stall_count;

  modport master (
    output stall, flush, fwa, fwb, rf_a, rf_b, ex_fwd, mem_fwd, wb_fwd, id_imm,
           id_valid, id_op_code, id_rd, id_rw, id_mem_rd, id_mem_wr,
    input  ex_a, ex_b, ex_imm, ex_op_code, ex_rd, ex_rw, ex_mem_rd, ex_mem_wr,
           ex_valid, pc_write, ifid_write, stall_count
  );

  modport slave (
    input  stall, flush, fwa, fwb, rf_a, rf_b, ex_fwd, mem_fwd, wb_fwd, id_imm,
           id_valid, id_op_code, id_rd, id_rw, id_mem_rd, id_mem_wr,
    output ex_a, ex_b, ex_imm, ex_op_code, ex_rd, ex_rw, ex_mem_rd, ex_mem_wr,
           ex_valid, pc_write, ifid_write, stall_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register. Resolves the forwarded ALU operands in decode and inserts bubbles on stall or flush.
// It also drives the PC and IF/ID hold enables and a saturating stall-cycle counter.
module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int RW  = 4,
  parameter int OPW = 6,
  parameter int CW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_operand_stage_if.slave bus
);

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          bubble;

  always_comb begin
    op_a = bus.rf_a;
    unique case (bus.fwa)
      2'b00: op_a = bus.rf_a;
      2'b01: op_a = bus.ex_fwd;
      2'b10: op_a = bus.mem_fwd;
      2'b11: op_a = bus.wb_fwd;
    endcase
  end

  always_comb begin
    op_b = bus.rf_b;
    unique case (bus.fwb)
      2'b00: op_b = bus.rf_b;
      2'b01: op_b = bus.ex_fwd;
      2'b10: op_b = bus.mem_fwd;
      2'b11: op_b = bus.wb_fwd;
    endcase
  end

  assign bubble = bus.flush | bus.stall;

  // Flush overrides stall so that the branch target is fetched.
  assign bus.pc_write   = ~bus.stall | bus.flush;
  assign bus.ifid_write = ~bus.stall | bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ex_a       <= '0;
      bus.ex_b       <= '0;
      bus.ex_imm     <= '0;
      bus.ex_op_code <= '0;
      bus.ex_rd      <= '0;
      bus.ex_rw      <= 1'b0;
      bus.ex_mem_rd  <= 1'b0;
      bus.ex_mem_wr  <= 1'b0;
      bus.ex_valid   <= 1'b0;
    end else if (bubble) begin
      bus.ex_a       <= '0;
      bus.ex_b       <= '0;
      bus.ex_imm     <= '0;
      bus.ex_op_code <= '0;
      bus.ex_rd      <= '0;
      bus.ex_rw      <= 1'b0;
      bus.ex_mem_rd  <= 1'b0;
      bus.ex_mem_wr  <= 1'b0;
      bus.ex_valid   <= 1'b0;
    end else begin
      // An invalid slot still carries its fields but must have no side effects.
      bus.ex_a       <= op_a;
      bus.ex_b       <= op_b;
      bus.ex_imm     <= bus.id_imm;
      bus.ex_op_code <= bus.id_op_code;
      bus.ex_rd      <= bus.id_rd;
      bus.ex_rw      <= bus.id_rw & bus.id_valid;
      bus.ex_mem_rd  <= bus.id_mem_rd & bus.id_valid;
      bus.ex_mem_wr  <= bus.id_mem_wr & bus.id_valid;
      bus.ex_valid   <= bus.id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stall_count <= '0;
    end else if (bus.stall && !bus.flush && (bus.stall_count != {CW{1'b1}})) begin
      bus.stall_count <= bus.stall_count + CW'(1);
    end
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Consumes the forwarding selects (fwa, fwb) and the load-use stall produced by the forwarding/stall unit.
- Resolves the final ALU operands in the decode stage and registers them with the decoded control fields into the ID/EX pipeline register.
- Inserts a bubble on stall or flush, drives the PC and IF/ID hold enables, and keeps a saturating count of stall cycles for performance debug.
- Sits between decode/register-file read and the execute stage.

Parameters:
- DW, 32, datapath width of operands and results.
- RW, 4, register index width (16 registers).
- OPW, 6, op_code width.
- CW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  load-use stall from the forwarding/stall unit.
- flush  in  1  kill the instruction in ID (taken branch/jump resolved in EX).
- fwa  in  2  operand A select: 00 register file, 01 stage-2 (EX) result, 10 stage-3 (MEM) result, 11 stage-4 (WB) result.
- fwb  in  2  operand B select, same encoding as fwa.
- rf_a  in  DW  register-file read data for rs.
- rf_b  in  DW  register-file read data for rt.
- ex_fwd  in  DW  stage-2 ALU result.
- mem_fwd  in  DW  stage-3 result.
- wb_fwd  in  DW  stage-4 write-back data.
- id_imm  in  DW  extended immediate.
- id_valid  in  1  the ID slot holds a real instruction.
- id_op_code  in  OPW  decoded op_code.
- id_rd  in  RW  destination register.
- id_rw  in  1  register-write enable.
- id_mem_rd  in  1  load.
- id_mem_wr  in  1  store.
- ex_a  out  DW  registered operand A.
- ex_b  out  DW  registered operand B (also store data).
- ex_imm  out  DW  registered immediate.
- ex_op_code  out  OPW  registered op_code.
- ex_rd  out  RW  registered destination register.
- ex_rw  out  1  registered register-write enable.
- ex_mem_rd  out  1  registered load flag.
- ex_mem_wr  out  1  registered store flag.
- ex_valid  out  1  the EX slot holds a real instruction.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID register enable (combinational).
- stall_count  out  CW  saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, immediate on reset=1): all ex_* outputs are 0, ex_valid is 0, stall_count is 0. A bubble is encoded as all-zero ex_* fields.
- Operand mux (combinational):
  - A = fwa 00 ? rf_a : 01 ? ex_fwd : 10 ? mem_fwd : wb_fwd.
  - B uses the same selection driven by fwb, with rf_b as the 00 source.
- Register update, each rising clk edge, in priority order:
  - flush=1: load a bubble (valid, rw, mem_rd, mem_wr, op_code, rd, a, b, imm all 0).
  - else stall=1: load a bubble (same as flush).
  - else: load the selected A and B plus id_imm, id_op_code, id_rd, id_rw, id_mem_rd, id_mem_wr, and id_valid.
- id_valid=0 with no stall or flush: fields still load, but ex_rw, ex_mem_rd and ex_mem_wr are forced to 0 so an invalid slot has no side effects.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs; no internal buffering beyond the single register.
- Hold enables:
  - pc_write = ifid_write = ~stall | flush.
  - Flush wins, so the branch target loads even if stall is asserted in the same cycle.
- Multi-cycle stall: every stalled cycle inserts one bubble while PC and IF/ID hold. The instruction issues on the first cycle stall=0, using the fwa/fwb values of that cycle.
- stall_count: +1 on each rising edge where stall=1 and flush=0. It saturates at 2^CW-1 and never wraps; it clears only on reset.
- Reset asserted mid-stall: outputs clear immediately. After reset deasserts, pc_write follows the stall input.
- Forward selects are used as-is; this block does not check them against the register indices.

Test Plan:
- Reset with rf_a=0x11, ex_fwd=0x22, fwa=01, clocking active -> ex_a=0, ex_valid=0, stall_count=0; after release, 1 edge -> ex_a=0x22.
- Forward sweep: rf_a=1, ex_fwd=2, mem_fwd=3, wb_fwd=4, fwa stepped 00/01/10/11, fwb held 00, rf_b=9 -> ex_a=1,2,3,4 on successive edges; ex_b=9 throughout.
- Load-use: stall=1 for 1 cycle with id_rw=1, id_rd=5 -> pc_write=ifid_write=0 during the stall; next ex_valid=0, ex_rw=0; the following edge with stall=0 -> ex_rd=5, ex_rw=1, stall_count=1.
- Stall and flush in the same cycle -> bubble, pc_write=1, stall_count unchanged.
- Store through forwarding: id_mem_wr=1, fwb=10, mem_fwd=0xDEAD -> ex_mem_wr=1, ex_b=0xDEAD.
- Counter saturation with CW=4: stall held 20 cycles -> stall_count reaches 15 and stays at 15.
